// File: rtl/alu_pipe.sv
// Single-stage pipelined EXE ALU: registered result, valid/ready handshake, NZCV status register.
// Shift/rotate opcodes are compiled in only when ALU_PIPE_SHIFT_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       exe_cmd,
    input  logic             s_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] w,
    output logic [3:0]       sr
);
    localparam logic [3:0] OP_MOV = 4'b0001, OP_MVN = 4'b1001, OP_ADD = 4'b0010,
                           OP_ADC = 4'b0011, OP_SUB = 4'b0100, OP_SBC = 4'b0101,
                           OP_AND = 4'b0110, OP_ORR = 4'b0111, OP_EOR = 4'b1000;
    localparam int MSB = WIDTH - 1;

    logic             acc;
    logic             upd;
    logic             c_n, v_n;
    logic             cin, bin;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum, diff;
    logic [3:0]       nzcv_n;

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // Carry/borrow-in taken from the live status register, so back-to-back ADC/SBC chain freely.
    assign cin  = (exe_cmd == OP_ADC) && sr[1];
    assign bin  = (exe_cmd == OP_SBC) && !sr[1];
    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};

`ifdef ALU_PIPE_SHIFT_EN
    localparam logic [3:0] OP_LSL = 4'b1010, OP_LSR = 4'b1011, OP_ASR = 4'b1100, OP_ROR = 4'b1101;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     shl, shr, sha;
    logic [2*WIDTH-1:0] rot;
    // Extra bit on the outgoing side of each shifter captures the last bit shifted out.
    assign sh  = b[SHW-1:0];
    assign shl = {1'b0, a} << sh;
    assign shr = {a, 1'b0} >> sh;
    assign sha = $signed({a, 1'b0}) >>> sh;
    assign rot = {a, a} >> sh;
`endif

    always_comb begin
        res = '0;
        c_n = sr[1];
        v_n = sr[0];
        upd = 1'b0;
        case (exe_cmd)
            OP_MOV: begin res = b;     upd = 1'b1; end
            OP_MVN: begin res = ~b;    upd = 1'b1; end
            OP_AND: begin res = a & b; upd = 1'b1; end
            OP_ORR: begin res = a | b; upd = 1'b1; end
            OP_EOR: begin res = a ^ b; upd = 1'b1; end
            OP_ADD, OP_ADC: begin
                res = sum[WIDTH-1:0];
                c_n = sum[WIDTH];
                v_n = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
                upd = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                res = diff[WIDTH-1:0];
                c_n = !diff[WIDTH];
                v_n = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
                upd = 1'b1;
            end
`ifdef ALU_PIPE_SHIFT_EN
            OP_LSL: begin
                upd = 1'b1;
                res = shl[WIDTH-1:0];
                if (sh != '0) c_n = shl[WIDTH];
            end
            OP_LSR: begin
                upd = 1'b1;
                res = shr[WIDTH:1];
                if (sh != '0) c_n = shr[0];
            end
            OP_ASR: begin
                upd = 1'b1;
                res = sha[WIDTH:1];
                if (sh != '0) c_n = sha[0];
            end
            OP_ROR: begin
                upd = 1'b1;
                res = rot[WIDTH-1:0];
                if (sh != '0) c_n = rot[WIDTH-1];
            end
`endif
            default: ;
        endcase
    end

    assign nzcv_n = {res[MSB], res == '0, c_n, v_n};

    // Flush beats acceptance: the accepted op is dropped and its flag write suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            w         <= '0;
            sr        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            w         <= res;
            if (s_in && upd) sr <= nzcv_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe; expected values are hand-computed constants.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b, w;
    logic [3:0]  exe_cmd, sr;
    logic        s_in, flush, out_valid, out_ready;

    int n_vec = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .exe_cmd(exe_cmd), .s_in(s_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .w(w), .sr(sr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one op for one edge, then drop in_valid just after the edge.
    task automatic op(input logic [3:0] cmd, input logic [31:0] av, input logic [31:0] bv, input logic s);
        @(negedge clk);
        exe_cmd = cmd; a = av; b = bv; s_in = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'($urandom); a = $urandom; b = $urandom;
        exe_cmd = 4'($urandom); s_in = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w", w, 0);
        chk("rst_sr", sr, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_ir", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
        chk("add_ovf_w", w, 32'h8000_0000);
        chk("add_ovf_sr", sr, 4'b1001);
        chk("add_ovf_ov", out_valid, 1);
        op(4'b0100, 32'd5, 32'd5, 1'b1);
        chk("sub_eq_w", w, 0);
        chk("sub_eq_sr", sr, 4'b0110);

        op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1);
        chk("add_cy_sr", sr, 4'b0110);
        op(4'b0011, 32'h0, 32'h0, 1'b1);
        chk("adc_w", w, 32'h1);
        chk("adc_sr", sr, 4'b0000);
        op(4'b0101, 32'd5, 32'd3, 1'b1);
        chk("sbc_w", w, 32'h1);
        chk("sbc_sr", sr, 4'b0010);

        op(4'b1110, 32'd5, 32'd5, 1'b1);
        chk("inv_w", w, 0);
        chk("inv_sr", sr, 4'b0010);
        op(4'b1001, 32'h0, 32'h0, 1'b1);
        chk("mvn_w", w, 32'hFFFF_FFFF);
        chk("mvn_sr", sr, 4'b1010);
        op(4'b0110, 32'hF0F0_1234, 32'h0F0F_FFFF, 1'b0);
        chk("and_w", w, 32'h0000_1234);
        chk("and_sr", sr, 4'b1010);

        // Backpressure: result held, second op waits until out_ready returns.
        idle();
        chk("drain_ov", out_valid, 0);
        @(negedge clk);
        out_ready = 1'b0;
        exe_cmd = 4'b0010; a = 32'd2; b = 32'd3; s_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_acc_w", w, 32'd5);
        exe_cmd = 4'b0100; a = 32'd9; b = 32'd2; s_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_w", w, 32'd5);
            chk("bp_ir", in_ready, 0);
            chk("bp_sr", sr, 4'b1010);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ir", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_rel_w", w, 32'd7);
        chk("bp_rel_sr", sr, 4'b0010);
        chk("bp_rel_ov", out_valid, 1);

        @(negedge clk);
        flush = 1'b1;
        op(4'b0010, 32'h0, 32'h0, 1'b1);
        flush = 1'b0;
        chk("fl_ov", out_valid, 0);
        chk("fl_sr", sr, 4'b0010);

        op(4'b0010, 32'h0, 32'h0, 1'b1);
        chk("pre_sh_sr", sr, 4'b0100);
        op(4'b1011, 32'h8000_0001, 32'h1, 1'b1);
`ifdef ALU_PIPE_SHIFT_EN
        chk("lsr_w", w, 32'h4000_0000);
        chk("lsr_sr", sr, 4'b0010);
        op(4'b1100, 32'h8000_0000, 32'h4, 1'b1);
        chk("asr_w", w, 32'hF800_0000);
        chk("asr_sr", sr, 4'b1000);
        op(4'b1010, 32'h3, 32'h20, 1'b1);
        chk("lsl0_w", w, 32'h3);
        chk("lsl0_sr", sr, 4'b0000);
        op(4'b1101, 32'h0000_0003, 32'h1, 1'b1);
        chk("ror_w", w, 32'h8000_0001);
        chk("ror_sr", sr, 4'b1010);
`else
        chk("lsr_off_w", w, 0);
        chk("lsr_off_sr", sr, 4'b0100);
`endif

        // Async reset while a result is pending, checked before any further edge.
        op(4'b0010, 32'h1, 32'h1, 1'b1);
        chk("pre_rst_ov", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_w", w, 0);
        chk("arst_sr", sr, 0);
        chk("arst_ir", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        op(4'b0001, 32'h0, 32'h55, 1'b1);
        chk("post_rst_w", w, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
